// File: rtl/dynamixel_write_scheduler.sv
// -----------------------------------------------------------------------------
// dynamixel_write_scheduler
//
// Shares one Dynamixel Protocol 2.0 sync-write transmitter (broadcast to four
// fixed servo IDs) between three requester channels. Each channel posts an
// address, a data length and four per-servo values into its own pending slot.
// A round-robin arbiter picks one pending slot, drives the transmitter with a
// one-cycle send pulse and then keeps the command frozen for the frame time
// plus a bus gap. The transmitter reports neither busy nor done, so the frame
// time is computed here from the data length.
//
// Parameters
//   clocks_per_bit  UART bit period in clocks (must match the transmitter)
//   gap_bits        idle bit-times inserted after every frame
//
// Ports
//   clock_i                 system clock
//   reset_i                 synchronous, active-high reset
//   reqN_i                  one-cycle request strobe for channel N
//   addrN_i / lenN_i        control-table address / data length (1, 2 or 4)
//   dataN_i                 servo values: [31:0] id1 .. [127:96] id4
//   pending_o[N]            channel N holds an unsent command
//   overwrite_o[N]          pulse: channel N replaced an unsent command
//   reject_o[N]             pulse: channel N posted an illegal length
//   grant_o[N]              pulse with tx_send_o naming the channel being sent
//   tx_send_o               one-cycle send pulse to the transmitter
//   tx_address_o, tx_data_len_o, tx_value1_o..tx_value4_o
//                           command presented to the transmitter
// -----------------------------------------------------------------------------
module dynamixel_write_scheduler #(
   parameter int clocks_per_bit = 1,
   parameter int gap_bits       = 20
) (
   input  logic          clock_i,
   input  logic          reset_i,
   input  logic          req0_i,
   input  logic          req1_i,
   input  logic          req2_i,
   input  logic [15:0]   addr0_i,
   input  logic [15:0]   addr1_i,
   input  logic [15:0]   addr2_i,
   input  logic [15:0]   len0_i,
   input  logic [15:0]   len1_i,
   input  logic [15:0]   len2_i,
   input  logic [127:0]  data0_i,
   input  logic [127:0]  data1_i,
   input  logic [127:0]  data2_i,
   output logic [2:0]    pending_o,
   output logic [2:0]    overwrite_o,
   output logic [2:0]    reject_o,
   output logic [2:0]    grant_o,
   output logic          tx_send_o,
   output logic [15:0]   tx_address_o,
   output logic [15:0]   tx_data_len_o,
   output logic [31:0]   tx_value1_o,
   output logic [31:0]   tx_value2_o,
   output logic [31:0]   tx_value3_o,
   output logic [31:0]   tx_value4_o
);

   // Frame length in bytes is 18 + 4*len; each byte is 10 bit-times on the wire.
   localparam int WIN1 = ((18 + 4 * 1) * 10 + gap_bits) * clocks_per_bit;
   localparam int WIN2 = ((18 + 4 * 2) * 10 + gap_bits) * clocks_per_bit;
   localparam int WIN4 = ((18 + 4 * 4) * 10 + gap_bits) * clocks_per_bit;

   // Sized for the longest frame at the slowest supported bit period.
   localparam int CNT_W = $clog2(((18 + 4 * 4) * 10 + gap_bits) * 1024 + 1);

   localparam logic [CNT_W-1:0] WIN1_M1 = CNT_W'(WIN1 - 1);
   localparam logic [CNT_W-1:0] WIN2_M1 = CNT_W'(WIN2 - 1);
   localparam logic [CNT_W-1:0] WIN4_M1 = CNT_W'(WIN4 - 1);

   typedef enum logic [1:0] {
      ST_HOLDOFF = 2'd0,
      ST_IDLE    = 2'd1,
      ST_WAIT    = 2'd2
   } state_t;

   // Counter reload for a frame of the given (already validated) length.
   function automatic logic [CNT_W-1:0] win_m1(input logic [15:0] len);
      if (len == 16'd1) begin
         win_m1 = WIN1_M1;
      end else if (len == 16'd2) begin
         win_m1 = WIN2_M1;
      end else begin
         win_m1 = WIN4_M1;
      end
   endfunction

   // ---------------------------------------------------------------------------
   // Channel inputs gathered into arrays so the slots can be generated.
   // ---------------------------------------------------------------------------
   logic          req_w  [3];
   logic [15:0]   addr_w [3];
   logic [15:0]   len_w  [3];
   logic [127:0]  data_w [3];

   assign req_w[0]  = req0_i;
   assign req_w[1]  = req1_i;
   assign req_w[2]  = req2_i;
   assign addr_w[0] = addr0_i;
   assign addr_w[1] = addr1_i;
   assign addr_w[2] = addr2_i;
   assign len_w[0]  = len0_i;
   assign len_w[1]  = len1_i;
   assign len_w[2]  = len2_i;
   assign data_w[0] = data0_i;
   assign data_w[1] = data1_i;
   assign data_w[2] = data2_i;

   // Slot contents seen by the arbiter.
   logic [2:0]    pending_w;
   logic [15:0]   slot_addr_w [3];
   logic [15:0]   slot_len_w  [3];
   logic [127:0]  slot_data_w [3];

   // One-hot channel being granted on this edge (from the FSM).
   logic [2:0]    grant_now;

   // ---------------------------------------------------------------------------
   // Pending slots, one per channel.
   // ---------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         logic          legal_len;
         logic          pend_q;
         logic          over_q;
         logic          rej_q;
         logic [15:0]   addr_q;
         logic [15:0]   len_q;
         logic [127:0]  data_q;

         assign legal_len = (len_w[gi] == 16'd1) || (len_w[gi] == 16'd2) ||
                            (len_w[gi] == 16'd4);

         always_ff @(posedge clock_i) begin
            if (reset_i) begin
               pend_q <= 1'b0;
               over_q <= 1'b0;
               rej_q  <= 1'b0;
               addr_q <= '0;
               len_q  <= '0;
               data_q <= '0;
            end else begin
               // A slot granted on this same edge is already being sent, so a
               // new request refills it rather than overwriting it.
               over_q <= req_w[gi] && legal_len && pend_q && !grant_now[gi];
               rej_q  <= req_w[gi] && !legal_len;
               if (req_w[gi] && legal_len) begin
                  addr_q <= addr_w[gi];
                  len_q  <= len_w[gi];
                  data_q <= data_w[gi];
                  pend_q <= 1'b1;
               end else if (grant_now[gi]) begin
                  pend_q <= 1'b0;
               end
            end
         end

         assign pending_w[gi]   = pend_q;
         assign overwrite_o[gi] = over_q;
         assign reject_o[gi]    = rej_q;
         assign slot_addr_w[gi] = addr_q;
         assign slot_len_w[gi]  = len_q;
         assign slot_data_w[gi] = data_q;
      end
   endgenerate

   assign pending_o = pending_w;

   // ---------------------------------------------------------------------------
   // Round-robin pick: first pending channel after the last winner.
   // ---------------------------------------------------------------------------
   logic [1:0]    ptr_q;
   logic [1:0]    ptr_d;
   logic [1:0]    cand1;
   logic [1:0]    cand2;
   logic [1:0]    sel;
   logic [15:0]   sel_addr;
   logic [15:0]   sel_len;
   logic [127:0]  sel_data;

   always_comb begin
      cand1 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
      cand2 = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
      if (pending_w[cand1]) begin
         sel = cand1;
      end else if (pending_w[cand2]) begin
         sel = cand2;
      end else begin
         sel = ptr_q;
      end
   end

   always_comb begin
      sel_addr = slot_addr_w[0];
      sel_len  = slot_len_w[0];
      sel_data = slot_data_w[0];
      case (sel)
         2'd1: begin
            sel_addr = slot_addr_w[1];
            sel_len  = slot_len_w[1];
            sel_data = slot_data_w[1];
         end
         2'd2: begin
            sel_addr = slot_addr_w[2];
            sel_len  = slot_len_w[2];
            sel_data = slot_data_w[2];
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Scheduler FSM.
   // ---------------------------------------------------------------------------
   state_t            state_q;
   state_t            state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              grant_valid;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      grant_now   = 3'b000;
      grant_valid = 1'b0;
      case (state_q)
         ST_HOLDOFF, ST_WAIT: begin
            // Return to IDLE on the edge where the counter reaches zero, so the
            // next send lands exactly one window after the previous one.
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (|pending_w) begin
               grant_valid = 1'b1;
               grant_now   = 3'b001 << sel;
               ptr_d       = sel;
               cnt_d       = win_m1(sel_len);
               state_d     = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_HOLDOFF;
            cnt_d   = WIN4_M1;
         end
      endcase
   end

   logic          tx_send_q;
   logic [2:0]    grant_q;
   logic [15:0]   tx_address_q;
   logic [15:0]   tx_data_len_q;
   logic [127:0]  tx_values_q;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         // The transmitter has no reset and may still be mid-frame, so wait
         // out the longest possible frame before the first send.
         state_q       <= ST_HOLDOFF;
         cnt_q         <= WIN4_M1;
         ptr_q         <= 2'd2;
         tx_send_q     <= 1'b0;
         grant_q       <= 3'b000;
         tx_address_q  <= '0;
         tx_data_len_q <= '0;
         tx_values_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         tx_send_q <= grant_valid;
         grant_q   <= grant_now;
         // Command registers only change at a grant; the transmitter samples
         // them byte by byte throughout the frame.
         if (grant_valid) begin
            tx_address_q  <= sel_addr;
            tx_data_len_q <= sel_len;
            tx_values_q   <= sel_data;
         end
      end
   end

   assign tx_send_o     = tx_send_q;
   assign grant_o       = grant_q;
   assign tx_address_o  = tx_address_q;
   assign tx_data_len_o = tx_data_len_q;
   assign tx_value1_o   = tx_values_q[31:0];
   assign tx_value2_o   = tx_values_q[63:32];
   assign tx_value3_o   = tx_values_q[95:64];
   assign tx_value4_o   = tx_values_q[127:96];

endmodule

// File: tb/tb_dynamixel_write_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for dynamixel_write_scheduler (clocks_per_bit=1, gap_bits=20).
// A time-based reference model tracks pending slots, the round-robin pointer
// and the earliest edge at which the next frame may start.
// -----------------------------------------------------------------------------
module tb_dynamixel_write_scheduler;

   localparam int CPB = 1;
   localparam int GAP = 20;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset;
   logic          rq [3];
   logic [15:0]   ad [3];
   logic [15:0]   ln [3];
   logic [127:0]  dt [3];

   logic [2:0]    pending, overwrite, reject, grant;
   logic          tx_send;
   logic [15:0]   tx_address, tx_data_len;
   logic [31:0]   v1, v2, v3, v4;

   dynamixel_write_scheduler #(
      .clocks_per_bit (CPB),
      .gap_bits       (GAP)
   ) dut (
      .clock_i       (clock),
      .reset_i       (reset),
      .req0_i        (rq[0]),
      .req1_i        (rq[1]),
      .req2_i        (rq[2]),
      .addr0_i       (ad[0]),
      .addr1_i       (ad[1]),
      .addr2_i       (ad[2]),
      .len0_i        (ln[0]),
      .len1_i        (ln[1]),
      .len2_i        (ln[2]),
      .data0_i       (dt[0]),
      .data1_i       (dt[1]),
      .data2_i       (dt[2]),
      .pending_o     (pending),
      .overwrite_o   (overwrite),
      .reject_o      (reject),
      .grant_o       (grant),
      .tx_send_o     (tx_send),
      .tx_address_o  (tx_address),
      .tx_data_len_o (tx_data_len),
      .tx_value1_o   (v1),
      .tx_value2_o   (v2),
      .tx_value3_o   (v3),
      .tx_value4_o   (v4)
   );

   wire [12:0]  dut_st = {pending, overwrite, reject, grant, tx_send};
   wire [159:0] dut_tx = {tx_address, tx_data_len, v1, v2, v3, v4};

   // Reference model state
   logic [2:0]    m_pend, m_over, m_rej, m_grant;
   logic          m_send;
   logic [159:0]  m_tx;
   logic [15:0]   m_addr [3];
   logic [15:0]   m_len  [3];
   logic [127:0]  m_data [3];
   int            m_ptr;
   int            m_ready;

   int ecount = 0;
   int last_edge = 0;
   int r_edge = 0;
   int tests = 0;
   int fails = 0;

   function automatic int win(input int len);
      return ((18 + 4 * len) * 10 + GAP) * CPB;
   endfunction

   function automatic logic [12:0] m_status();
      return {m_pend, m_over, m_rej, m_grant, m_send};
   endfunction

   task automatic model_edge();
      logic [2:0] pend_old;
      int gch;
      int c;
      logic legal;
      if (reset) begin
         m_pend = '0; m_over = '0; m_rej = '0; m_grant = '0; m_send = 1'b0;
         m_tx = '0; m_ptr = 2; m_ready = ecount + win(4);
         return;
      end
      pend_old = m_pend;
      gch = -1;
      m_send = 1'b0;
      m_grant = '0;
      if (ecount >= m_ready && m_pend != 3'b000) begin
         for (int k = 1; k <= 3; k++) begin
            c = (m_ptr + k) % 3;
            if (gch < 0 && m_pend[c]) gch = c;
         end
         m_send = 1'b1;
         m_grant[gch] = 1'b1;
         m_ptr = gch;
         m_pend[gch] = 1'b0;
         m_ready = ecount + win(int'(m_len[gch]));
         m_tx = {m_addr[gch], m_len[gch], m_data[gch][31:0], m_data[gch][63:32],
                 m_data[gch][95:64], m_data[gch][127:96]};
      end
      for (int k = 0; k < 3; k++) begin
         legal = (ln[k] == 16'd1) || (ln[k] == 16'd2) || (ln[k] == 16'd4);
         m_over[k] = rq[k] && legal && pend_old[k] && (gch != k);
         m_rej[k]  = rq[k] && !legal;
         if (rq[k] && legal) begin
            m_addr[k] = ad[k];
            m_len[k]  = ln[k];
            m_data[k] = dt[k];
            m_pend[k] = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      last_edge = ecount;
      ecount++;
      #1;
      for (int k = 0; k < 3; k++) rq[k] = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      r_edge = last_edge;
   endtask

   task automatic post(input int ch, input logic [15:0] a, input logic [15:0] l,
                       input logic [127:0] d);
      rq[ch] = 1'b1;
      ad[ch] = a;
      ln[ch] = l;
      dt[ch] = d;
   endtask

   // Advance until the model says a new frame may start (bounded).
   task automatic wait_ready();
      for (int i = 0; i < 2000 && ecount < m_ready; i++) tick();
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      tests++;
      if (dut_st !== 13'd0) begin
         fails++;
         $display("FAIL reset_status got=%h exp=%h", dut_st, 13'd0);
      end
      tests++;
      if (dut_tx !== 160'd0) begin
         fails++;
         $display("FAIL reset_tx got=%h exp=0", dut_tx);
      end
   endtask

   task automatic test_single();
      int first;
      int nsend;
      int unstable;
      logic [159:0] exp_tx;
      exp_tx = {16'd116, 16'd4, 32'd1, 32'd2, 32'd3, 32'd4};
      first = -1; nsend = 0; unstable = 0;
      do_reset();
      while (ecount < r_edge + 10) tick();
      post(0, 16'd116, 16'd4, {32'd4, 32'd3, 32'd2, 32'd1});
      repeat (760) begin
         tick();
         tests++;
         if (dut_st !== m_status()) begin
            fails++;
            $display("FAIL single_status edge=%0d got=%h exp=%h", last_edge, dut_st, m_status());
         end
         tests++;
         if (dut_tx !== m_tx) begin
            fails++;
            $display("FAIL single_tx edge=%0d got=%h exp=%h", last_edge, dut_tx, m_tx);
         end
         if (tx_send === 1'b1) begin
            nsend++;
            if (first < 0) first = last_edge;
            tests++;
            if (grant !== 3'b001) begin
               fails++;
               $display("FAIL single_grant got=%b exp=001", grant);
            end
         end
         if (first >= 0 && dut_tx !== exp_tx) unstable++;
      end
      tests++;
      if (first - r_edge !== 360) begin
         fails++;
         $display("FAIL single_holdoff got=%0d exp=360", first - r_edge);
      end
      tests++;
      if (nsend !== 1) begin
         fails++;
         $display("FAIL single_count got=%0d exp=1", nsend);
      end
      tests++;
      if (unstable !== 0) begin
         fails++;
         $display("FAIL single_stable got=%0d unstable cycles exp=0", unstable);
      end
      $display("[TB] single: send at +%0d, %0d sends", first - r_edge, nsend);
   endtask

   task automatic test_back_to_back();
      int s_edge [3];
      logic [2:0] s_grant [3];
      logic [2:0] s_pend [3];
      int n;
      n = 0;
      do_reset();
      while (ecount <= r_edge + 360) tick();
      post(0, 16'd10, 16'd4, {$urandom, $urandom, $urandom, $urandom});
      post(1, 16'd11, 16'd4, {$urandom, $urandom, $urandom, $urandom});
      post(2, 16'd12, 16'd4, {$urandom, $urandom, $urandom, $urandom});
      tick();
      tests++;
      if (pending !== 3'b111) begin
         fails++;
         $display("FAIL b2b_pending0 got=%b exp=111", pending);
      end
      repeat (1000) begin
         tick();
         tests++;
         if (dut_st !== m_status()) begin
            fails++;
            $display("FAIL b2b_status edge=%0d got=%h exp=%h", last_edge, dut_st, m_status());
         end
         if (tx_send === 1'b1 && n < 3) begin
            s_edge[n] = last_edge; s_grant[n] = grant; s_pend[n] = pending;
            n++;
         end
      end
      tests++;
      if (n !== 3) begin
         fails++;
         $display("FAIL b2b_count got=%0d exp=3", n);
      end else begin
         tests++;
         if ({s_grant[0], s_grant[1], s_grant[2]} !== 9'b001_010_100) begin
            fails++;
            $display("FAIL b2b_order got=%b %b %b exp=001 010 100", s_grant[0], s_grant[1], s_grant[2]);
         end
         tests++;
         if ({s_pend[0], s_pend[1], s_pend[2]} !== 9'b110_100_000) begin
            fails++;
            $display("FAIL b2b_pending got=%b %b %b exp=110 100 000", s_pend[0], s_pend[1], s_pend[2]);
         end
         tests++;
         if (s_edge[1] - s_edge[0] !== 360 || s_edge[2] - s_edge[1] !== 360) begin
            fails++;
            $display("FAIL b2b_spacing got=%0d,%0d exp=360,360", s_edge[1] - s_edge[0], s_edge[2] - s_edge[1]);
         end
      end
      $display("[TB] back_to_back: %0d sends", n);
   endtask

   task automatic test_short_frame();
      int s_edge [2];
      logic [2:0] s_grant [2];
      logic [15:0] s_len [2];
      int n;
      n = 0;
      wait_ready();
      post(1, 16'd20, 16'd1, {$urandom, $urandom, $urandom, $urandom});
      tick();
      post(2, 16'd21, 16'd4, {$urandom, $urandom, $urandom, $urandom});
      repeat (600) begin
         tick();
         tests++;
         if (dut_tx !== m_tx) begin
            fails++;
            $display("FAIL short_tx edge=%0d got=%h exp=%h", last_edge, dut_tx, m_tx);
         end
         if (tx_send === 1'b1 && n < 2) begin
            s_edge[n] = last_edge; s_grant[n] = grant; s_len[n] = tx_data_len;
            n++;
         end
      end
      tests++;
      if (n !== 2) begin
         fails++;
         $display("FAIL short_count got=%0d exp=2", n);
      end else begin
         tests++;
         if (s_edge[1] - s_edge[0] !== 240) begin
            fails++;
            $display("FAIL short_spacing got=%0d exp=240", s_edge[1] - s_edge[0]);
         end
         tests++;
         if ({s_grant[0], s_grant[1]} !== 6'b010_100 || s_len[0] !== 16'd1 || s_len[1] !== 16'd4) begin
            fails++;
            $display("FAIL short_order got=%b %b len %0d %0d exp=010 100 len 1 4", s_grant[0], s_grant[1], s_len[0], s_len[1]);
         end
      end
      $display("[TB] short_frame: spacing %0d", (n == 2) ? s_edge[1] - s_edge[0] : -1);
   endtask

   task automatic test_overwrite();
      int n0;
      logic [15:0] a0;
      n0 = 0; a0 = '0;
      wait_ready();
      post(1, 16'd200, 16'd4, {$urandom, $urandom, $urandom, $urandom});
      tick();
      repeat (10) tick();
      post(0, 16'd64, 16'd2, {$urandom, $urandom, $urandom, $urandom});
      tick();
      tests++;
      if (overwrite !== 3'b000) begin
         fails++;
         $display("FAIL ovw_first got=%b exp=000", overwrite);
      end
      repeat (5) tick();
      post(0, 16'd65, 16'd2, {$urandom, $urandom, $urandom, $urandom});
      tick();
      tests++;
      if (overwrite !== 3'b001) begin
         fails++;
         $display("FAIL ovw_second got=%b exp=001", overwrite);
      end
      tick();
      tests++;
      if (overwrite !== 3'b000) begin
         fails++;
         $display("FAIL ovw_pulse got=%b exp=000", overwrite);
      end
      repeat (500) begin
         tick();
         tests++;
         if (dut_st !== m_status()) begin
            fails++;
            $display("FAIL ovw_status edge=%0d got=%h exp=%h", last_edge, dut_st, m_status());
         end
         if (tx_send === 1'b1 && grant === 3'b001) begin
            n0++;
            a0 = tx_address;
         end
      end
      tests++;
      if (n0 !== 1 || a0 !== 16'd65) begin
         fails++;
         $display("FAIL ovw_frame got=%0d sends addr %0d exp=1 sends addr 65", n0, a0);
      end
      $display("[TB] overwrite: %0d ch0 sends, addr %0d", n0, a0);
   endtask

   task automatic test_reject();
      int n;
      n = 0;
      wait_ready();
      post(2, 16'd300, 16'd3, {$urandom, $urandom, $urandom, $urandom});
      tick();
      tests++;
      if (reject !== 3'b100 || pending !== 3'b000) begin
         fails++;
         $display("FAIL rej_pulse got=%b pend=%b exp=100 pend=000", reject, pending);
      end
      tick();
      tests++;
      if (reject !== 3'b000) begin
         fails++;
         $display("FAIL rej_clear got=%b exp=000", reject);
      end
      repeat (50) begin
         tick();
         if (tx_send === 1'b1) n++;
      end
      tests++;
      if (n !== 0) begin
         fails++;
         $display("FAIL rej_nosend got=%0d exp=0", n);
      end
      $display("[TB] reject: %0d sends", n);
   endtask

   task automatic test_reset_mid_wait();
      int first;
      first = -1;
      wait_ready();
      post(0, 16'd400, 16'd4, {$urandom, $urandom, $urandom, $urandom});
      tick();
      tick();
      tests++;
      if (tx_send !== 1'b1) begin
         fails++;
         $display("FAIL rmw_send got=%b exp=1", tx_send);
      end
      repeat (50) tick();
      post(1, 16'd401, 16'd2, {$urandom, $urandom, $urandom, $urandom});
      repeat (49) tick();
      tests++;
      if (pending !== 3'b010) begin
         fails++;
         $display("FAIL rmw_pending got=%b exp=010", pending);
      end
      do_reset();
      tests++;
      if (pending !== 3'b000 || tx_send !== 1'b0) begin
         fails++;
         $display("FAIL rmw_cleared got=pend %b send %b exp=pend 000 send 0", pending, tx_send);
      end
      post(1, 16'd402, 16'd2, {$urandom, $urandom, $urandom, $urandom});
      repeat (420) begin
         tick();
         if (tx_send === 1'b1 && first < 0) begin
            first = last_edge;
            tests++;
            if (grant !== 3'b010 || tx_address !== 16'd402) begin
               fails++;
               $display("FAIL rmw_grant got=%b addr %0d exp=010 addr 402", grant, tx_address);
            end
         end
      end
      tests++;
      if (first - r_edge !== 360) begin
         fails++;
         $display("FAIL rmw_holdoff got=%0d exp=360", first - r_edge);
      end
      $display("[TB] reset_mid_wait: send at +%0d", first - r_edge);
   endtask

   task automatic test_random();
      int nsend;
      int lsel;
      logic [15:0] lens [5];
      lens[0] = 16'd1; lens[1] = 16'd2; lens[2] = 16'd4; lens[3] = 16'd3; lens[4] = 16'd0;
      nsend = 0;
      do_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int k = 0; k < 3; k++) begin
            if ($urandom_range(0, 39) == 0) begin
               lsel = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 4)) : int'($urandom_range(0, 2));
               post(k, 16'($urandom), lens[lsel], {$urandom, $urandom, $urandom, $urandom});
            end
         end
         if ($urandom_range(0, 1499) == 0) reset = 1'b1;
         tick();
         reset = 1'b0;
         if (tx_send === 1'b1) nsend++;
         tests++;
         if (dut_st !== m_status()) begin
            fails++;
            $display("FAIL rand_status edge=%0d got=%h exp=%h", last_edge, dut_st, m_status());
         end
         tests++;
         if (dut_tx !== m_tx) begin
            fails++;
            $display("FAIL rand_tx edge=%0d got=%h exp=%h", last_edge, dut_tx, m_tx);
         end
      end
      $display("[TB] random: %0d sends over 4000 cycles", nsend);
   endtask

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         rq[k] = 1'b0; ad[k] = '0; ln[k] = 16'd1; dt[k] = '0;
         m_addr[k] = '0; m_len[k] = 16'd1; m_data[k] = '0;
      end
      m_pend = '0; m_over = '0; m_rej = '0; m_grant = '0; m_send = 1'b0;
      m_tx = '0; m_ptr = 2; m_ready = 0;
      #2;
      test_reset();
      test_single();
      test_back_to_back();
      test_short_frame();
      test_overwrite();
      test_reject();
      test_reset_mid_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dynamixel_write_scheduler.md
Name: dynamixel_write_scheduler

Overview:
- Shares one Dynamixel Protocol 2.0 sync-write transmitter (broadcast, 4 fixed servo IDs) between three requester channels, e.g. torque enable, goal position and profile velocity.
- Each channel posts an address, a data length and four per-servo values. The block latches them into a pending slot, picks a slot round-robin, drives the transmitter with a one-cycle send pulse, and holds the command stable for the full frame time plus a bus gap.
- The transmitter exposes no busy/done signal, so frame timing is computed here.

Parameters:
- clocks_per_bit, 1: UART bit period in clocks; must equal the transmitter's setting.
- gap_bits, 20: idle bit-times inserted after each frame before the next send.

Ports:
- clock  in  1  system clock; the block uses this single clock.
- reset  in  1  synchronous, active-high reset.
- req0, req1, req2  in  1 each  one-cycle request strobe per channel.
- addr0, addr1, addr2  in  16 each  control-table address.
- len0, len1, len2  in  16 each  data length in bytes; legal values are 1, 2 and 4.
- data0, data1, data2  in  128 each  servo values: [31:0] id1, [63:32] id2, [95:64] id3, [127:96] id4.
- pending  out  3  bit n set while channel n holds an unsent command.
- overwrite  out  3  one-cycle pulse: channel n's req replaced an unsent command.
- reject  out  3  one-cycle pulse: channel n's req carried an illegal length and was dropped.
- grant  out  3  one-cycle pulse, coincident with tx_send, naming the channel being sent.
- tx_send  out  1  one-cycle send pulse to the transmitter.
- tx_address  out  16  address to the transmitter.
- tx_data_len  out  16  data length to the transmitter.
- tx_value1, tx_value2, tx_value3, tx_value4  out  32 each  per-servo values to the transmitter.

Behaviour:
- Reset values:
  - All outputs 0; pending cleared; round-robin pointer = 2, so channel 0 wins first.
  - FSM enters HOLDOFF with counter = window(4) - 1.
- Frame window, computed per frame:
  - bytes(len) = 18 + 4*len, giving 22, 26 and 34 bytes for len 1, 2 and 4.
  - window(len) = (bytes*10 + gap_bits) * clocks_per_bit.
  - The counter must be wide enough for window(4) with clocks_per_bit up to 1024.
- Request capture, at each clock edge per channel:
  - A req with len in {1,2,4} latches addr, len and data into the slot and sets pending.
  - If pending was already set, the slot takes the latest contents and overwrite pulses; latest wins.
  - Any other len: slot unchanged, reject pulses.
- FSM:
  - HOLDOFF: counter decrements each cycle; at 0 go to IDLE. This covers a transmitter frame still in flight across a reset, since the transmitter itself has no reset.
  - IDLE: if any pending, pick the first pending channel starting at pointer+1 mod 3, wrapping. Load the tx_* registers from that slot, clear its pending, set pointer to the winner, and pulse tx_send and grant[winner] in the next cycle. Load counter = window(len) - 1 and go to WAIT.
  - WAIT: the tx_* values stay frozen, because the transmitter samples them byte by byte throughout the frame. Counter decrements each cycle; at 0 go to IDLE.
- Latency:
  - req at edge k sets pending after k.
  - With the FSM in IDLE, tx_send is high in the cycle after edge k+1.
  - Consecutive tx_send pulses are separated by exactly window(len of first frame) cycles when work is queued.
- Simultaneous events:
  - A req on the same cycle its slot is granted: the grant sends the old contents; the new contents stay pending (pending remains 1); no overwrite pulse.
  - Simultaneous reqs on several channels are all captured independently.
- Reset mid-WAIT: pending is discarded, tx_send stays 0, the FSM enters HOLDOFF with the full window(4) holdoff.
- tx_send is never asserted outside the IDLE-to-WAIT transition.

Test Plan (clocks_per_bit=1, gap_bits=20):
- Reset, then req0 (addr 116, len 4, data {1,2,3,4}) at cycle 10 -> no tx_send before holdoff ends at cycle 360. tx_send and grant=001 pulse once, with tx_address=116, tx_value1..4=1,2,3,4. Outputs stay stable for 360 cycles.
- req0, req1 and req2 in the same cycle, all len 4 -> grants in order 0, 1, 2, each tx_send exactly 360 cycles apart. pending steps 111 -> 110 -> 100 -> 000.
- req1 len 1 sent; req2 queued -> second tx_send exactly 240 cycles after the first.
- req0 twice while WAIT is busy, with addr 64 then 65 -> overwrite=001 on the second req; a single frame is sent with tx_address=65.
- req2 with len 3 -> reject=100 for one cycle; pending unchanged; no tx_send.
- Assert reset 100 cycles into WAIT with req1 pending -> pending=000 and tx_send=0. A new req1 after reset is sent only after 360 holdoff cycles.
